kalman_channel_scheduler: RTL and testbench

- Time-shares one multi-cycle 1D Kalman update engine (x, P update; A=1, H=1) among NUM_CH sensor channels.
- Holds per-channel context: x (Q15), P, Q_var and R_var (Q30). Channels are granted round-robin.
- For each granted channel: issues the context and measurement to the engine, waits for completion under a watchdog, writes back, then presents the estimate on a valid/ready output.
- Sits between the sensor front-ends and the shared filter datapath.

---
 rtl/kalman_pkg.sv | 31 +++
 rtl/kalman_channel_scheduler_rr_arbiter.sv | 37 +++
 rtl/kalman_channel_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_kalman_channel_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
`default_nettype none
// ============================================================================
// Package  : kalman_pkg
// Brief    : Shared types and default widths for the Kalman channel scheduler.
// Revision : 1.0
// ============================================================================
package kalman_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } sched_state_e;

    localparam int DEF_STATE_BITS = 16;
    localparam int DEF_STATE_Q    = 15;
    localparam int DEF_VAR_BITS   = 64;
    localparam int DEF_VAR_Q      = 30;

    localparam logic [DEF_VAR_BITS-1:0] P_INIT = DEF_VAR_BITS'(1) << DEF_VAR_Q;

    typedef struct packed {
        logic [DEF_STATE_BITS-1:0] x;
        logic [DEF_VAR_BITS-1:0]   p;
        logic [DEF_VAR_BITS-1:0]   q_var;
        logic [DEF_VAR_BITS-1:0]   r_var;
    } ch_ctx_t;

endpackage
`default_nettype wire

// File: rtl/kalman_channel_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter, search starts after last grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         i_req,
    input  logic [$clog2(NUM_CH)-1:0] i_last,
    output logic [NUM_CH-1:0]         o_gnt,
    output logic [$clog2(NUM_CH)-1:0] o_gnt_idx,
    output logic                      o_gnt_any
);

    localparam int c_idx_w = $clog2(NUM_CH);

    // Operand never exceeds 2*NUM_CH-1, so one conditional subtract is a full modulo.
    function automatic int wrap_idx(input int v);
        return (v >= NUM_CH) ? (v - NUM_CH) : v;
    endfunction

    always_comb begin
        o_gnt_any = 1'b0;
        o_gnt_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!o_gnt_any && i_req[wrap_idx(int'(i_last) + k)]) begin
                o_gnt_any = 1'b1;
                o_gnt_idx = c_idx_w'(wrap_idx(int'(i_last) + k));
            end
        end
        o_gnt = o_gnt_any ? (NUM_CH'(1) << o_gnt_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/kalman_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : kalman_channel_scheduler
// Brief    : Time-shares one 1D Kalman update engine among NUM_CH channels.
// Revision : 1.0
// ============================================================================
module kalman_channel_scheduler
    import kalman_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int STATE_BITS = DEF_STATE_BITS,
    parameter int STATE_Q    = DEF_STATE_Q,
    parameter int VAR_BITS   = DEF_VAR_BITS,
    parameter int VAR_Q      = DEF_VAR_Q,
    parameter int TIMEOUT    = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            z_valid,
    input  logic [NUM_CH*STATE_BITS-1:0] z_data,
    output logic [NUM_CH-1:0]            z_ready,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
    input  logic [VAR_BITS-1:0]          cfg_q_var,
    input  logic [VAR_BITS-1:0]          cfg_r_var,
    input  logic                         cfg_clr,
    output logic                         eng_start,
    output logic [STATE_BITS-1:0]        eng_x,
    output logic [VAR_BITS-1:0]          eng_p,
    output logic [VAR_BITS-1:0]          eng_q_var,
    output logic [VAR_BITS-1:0]          eng_r_var,
    output logic [STATE_BITS-1:0]        eng_z,
    input  logic                         eng_done,
    input  logic [STATE_BITS-1:0]        eng_x_new,
    input  logic [VAR_BITS-1:0]          eng_p_new,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic [STATE_BITS-1:0]        out_x,
    output logic                         timeout_err
);

    localparam int c_idx_w = $clog2(NUM_CH);
    localparam int c_wd_w  = $clog2(TIMEOUT);
    localparam logic [VAR_BITS-1:0] c_p_init  = VAR_BITS'(1) << VAR_Q;
    localparam logic [c_wd_w-1:0]   c_wd_last = c_wd_w'(TIMEOUT - 2);

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 2 ||
        STATE_Q >= STATE_BITS || VAR_Q >= VAR_BITS) begin : g_param_check
        $error("kalman_channel_scheduler: unsupported parameter set");
    end

    typedef struct packed {
        logic [STATE_BITS-1:0] x;
        logic [VAR_BITS-1:0]   p;
        logic [VAR_BITS-1:0]   q_var;
        logic [VAR_BITS-1:0]   r_var;
    } ctx_t;

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    ctx_t                  r_ctx [NUM_CH];
    logic [c_idx_w-1:0]    r_rr_last;
    logic [c_idx_w-1:0]    r_gnt;
    logic                  r_clr_pending;
    logic [c_wd_w-1:0]     r_wd;
    logic [STATE_BITS-1:0] r_eng_x;
    logic [STATE_BITS-1:0] r_eng_z;
    logic [VAR_BITS-1:0]   r_eng_p;
    logic [VAR_BITS-1:0]   r_eng_q;
    logic [VAR_BITS-1:0]   r_eng_r;
    logic [STATE_BITS-1:0] r_out_x;
    logic [c_idx_w-1:0]    r_out_ch;
    logic                  r_timeout_err;

    logic [NUM_CH-1:0]     w_arb_gnt;
    logic [c_idx_w-1:0]    w_arb_idx;
    logic                  w_arb_any;
    logic                  w_cfg_block;
    logic                  w_cfg_clr_inflight;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_abort;
    logic [STATE_BITS-1:0] w_z [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_z_unpack
        assign w_z[gi] = z_data[gi*STATE_BITS +: STATE_BITS];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req     (z_valid),
        .i_last    (r_rr_last),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_any (w_arb_any)
    );

    // A config write to the candidate channel wins; arbitration retries next cycle.
    assign w_cfg_block        = cfg_we && (cfg_ch == w_arb_idx);
    assign w_cfg_clr_inflight = cfg_we && cfg_clr && (cfg_ch == r_gnt) &&
                                ((r_state == START) || (r_state == WAIT));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && w_arb_any && !w_cfg_block) begin
                    w_accept    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                if (eng_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = OUT;
                end else if (r_wd == c_wd_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            OUT: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Engine operands are latched at grant so mid-flight config writes cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last     <= c_idx_w'(NUM_CH - 1);
            r_gnt         <= '0;
            r_clr_pending <= 1'b0;
            r_wd          <= '0;
            r_eng_x       <= '0;
            r_eng_z       <= '0;
            r_eng_p       <= '0;
            r_eng_q       <= '0;
            r_eng_r       <= '0;
            r_out_x       <= '0;
            r_out_ch      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt         <= w_arb_idx;
                r_rr_last     <= w_arb_idx;
                r_clr_pending <= 1'b0;
                r_eng_x       <= r_ctx[w_arb_idx].x;
                r_eng_p       <= r_ctx[w_arb_idx].p;
                r_eng_q       <= r_ctx[w_arb_idx].q_var;
                r_eng_r       <= r_ctx[w_arb_idx].r_var;
                r_eng_z       <= w_z[w_arb_idx];
            end
            if (w_cfg_clr_inflight) r_clr_pending <= 1'b1;
            if (r_state == START)     r_wd <= '0;
            else if (r_state == WAIT) r_wd <= r_wd + 1'b1;
            if (w_done) begin
                r_out_x  <= eng_x_new;
                r_out_ch <= r_gnt;
            end
            if (w_abort) r_timeout_err <= 1'b1;
        end
    end

    // Later assignments win: config clear overrides writeback or abort in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ctx[i] <= '{x: '0, p: c_p_init, q_var: '0, r_var: c_p_init};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_done && !r_clr_pending && (r_gnt == c_idx_w'(i))) begin
                    r_ctx[i].x <= eng_x_new;
                    r_ctx[i].p <= eng_p_new;
                end
                if (w_abort && (r_gnt == c_idx_w'(i))) begin
                    r_ctx[i].x <= '0;
                    r_ctx[i].p <= c_p_init;
                end
                if (cfg_we && (cfg_ch == c_idx_w'(i))) begin
                    r_ctx[i].q_var <= cfg_q_var;
                    r_ctx[i].r_var <= cfg_r_var;
                    if (cfg_clr) begin
                        r_ctx[i].x <= '0;
                        r_ctx[i].p <= c_p_init;
                    end
                end
            end
        end
    end

    assign z_ready     = w_accept ? w_arb_gnt : '0;
    assign eng_start   = (r_state == START);
    assign eng_x       = r_eng_x;
    assign eng_p       = r_eng_p;
    assign eng_q_var   = r_eng_q;
    assign eng_r_var   = r_eng_r;
    assign eng_z       = r_eng_z;
    assign out_valid   = (r_state == OUT);
    assign out_ch      = r_out_ch;
    assign out_x       = r_out_x;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_kalman_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_kalman_channel_scheduler
// Brief    : Directed self-checking bench with a fixed-latency engine model.
// Revision : 1.0
// ============================================================================
module tb_kalman_channel_scheduler;

    localparam int NUM_CH  = 4;
    localparam int SB      = 16;
    localparam int VB      = 64;
    localparam int TIMEOUT = 256;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    z_valid;
    logic [NUM_CH*SB-1:0] z_data;
    logic [NUM_CH-1:0]    z_ready;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [VB-1:0]        cfg_q_var;
    logic [VB-1:0]        cfg_r_var;
    logic                 cfg_clr;
    logic                 eng_start;
    logic [SB-1:0]        eng_x;
    logic [VB-1:0]        eng_p;
    logic [VB-1:0]        eng_q_var;
    logic [VB-1:0]        eng_r_var;
    logic [SB-1:0]        eng_z;
    logic                 eng_done;
    logic [SB-1:0]        eng_x_new;
    logic [VB-1:0]        eng_p_new;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_ch;
    logic [SB-1:0]        out_x;
    logic                 timeout_err;

    int            checks = 0;
    int            errors = 0;
    int            eng_lat;
    bit            eng_en;
    logic [SB-1:0] eng_xv;
    logic [VB-1:0] eng_pv;
    int            eng_cnt;
    int            ch;

    kalman_channel_scheduler #(
        .NUM_CH(NUM_CH), .STATE_BITS(SB), .STATE_Q(15),
        .VAR_BITS(VB), .VAR_Q(30), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .z_valid(z_valid), .z_data(z_data), .z_ready(z_ready),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_q_var(cfg_q_var),
        .cfg_r_var(cfg_r_var), .cfg_clr(cfg_clr),
        .eng_start(eng_start), .eng_x(eng_x), .eng_p(eng_p),
        .eng_q_var(eng_q_var), .eng_r_var(eng_r_var), .eng_z(eng_z),
        .eng_done(eng_done), .eng_x_new(eng_x_new), .eng_p_new(eng_p_new),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_x(out_x), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: eng_done comes L cycles after the cycle showing eng_start.
    initial begin
        eng_done  = 1'b0;
        eng_x_new = '0;
        eng_p_new = '0;
        eng_cnt   = 0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (eng_start) begin
                eng_cnt = eng_lat;
            end else if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0 && eng_en) begin
                    eng_done  = 1'b1;
                    eng_x_new = eng_xv;
                    eng_p_new = eng_pv;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in IDLE with z_valid[c] set; returns in the START cycle.
    task automatic grant_start(input int c, input logic [15:0] ex, input logic [63:0] ep,
                               input logic [15:0] ez);
        #1;
        chk("grant_z_ready", z_ready, 64'(1) << c);
        tick();
        chk("eng_start", eng_start, 1);
        chk("eng_x", eng_x, ex);
        chk("eng_p", eng_p, ep);
        chk("eng_z", eng_z, ez);
        z_valid[c] = 1'b0;
    endtask

    task automatic finish_out(input int c, input logic [15:0] ex);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("out_ch", out_ch, c);
        chk("out_x", out_x, ex);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        z_valid   = '0;
        z_data    = 64'h3333_2222_1111_4000;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_q_var = '0;
        cfg_r_var = '0;
        cfg_clr   = 1'b0;
        out_ready = 1'b0;
        eng_en    = 1'b1;
        eng_lat   = 3;
        eng_xv    = 16'h2000;
        eng_pv    = 64'h2000_0000;

        repeat (3) tick();
        z_valid = 4'b0001;
        #1;
        chk("rst_z_ready", z_ready, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_xz", {eng_x, eng_z}, 0);
        chk("rst_eng_p", eng_p, 0);
        chk("rst_eng_qr", eng_q_var | eng_r_var, 0);
        chk("rst_out", {out_valid, out_ch, out_x, timeout_err}, 0);
        tick();
        rst_n = 1'b1;

        // First update on channel 0 and minimum latency.
        grant_start(0, 16'h0000, 64'h4000_0000, 16'h4000);
        chk("first_q_var", eng_q_var, 0);
        chk("first_r_var", eng_r_var, 64'h4000_0000);
        repeat (3) tick();
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_ch", out_ch, 0);
        chk("lat_out_x", out_x, 16'h2000);

        // Backpressure in OUT with every channel requesting.
        z_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_x_ch", {out_x, out_ch}, {16'h2000, 2'd0});
            chk("hold_no_ready", z_ready, 0);
        end
        out_ready = 1'b1;
        tick();

        // Round-robin order 1,2,3,0; channel 0 now carries its updated context.
        for (int k = 0; k < 4; k++) begin
            ch = (k + 1) % 4;
            grant_start(ch, (ch == 0) ? 16'h2000 : 16'h0000,
                        (ch == 0) ? 64'h2000_0000 : 64'h4000_0000,
                        (ch == 0) ? 16'h4000 : 16'(ch * 16'h1111));
            finish_out(ch, 16'h2000);
        end

        // Watchdog abort on channel 1 while channel 2 waits.
        eng_en  = 1'b0;
        z_valid = 4'b0010;
        grant_start(1, 16'h2000, 64'h2000_0000, 16'h1111);
        z_valid[2] = 1'b1;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            chk("to_quiet", {out_valid, z_ready}, 0);
        end
        chk("to_err_before", timeout_err, 0);
        tick();
        chk("to_err_set", timeout_err, 1);
        chk("to_no_out", out_valid, 0);
        eng_en = 1'b1;
        grant_start(2, 16'h2000, 64'h2000_0000, 16'h2222);
        finish_out(2, 16'h2000);

        z_valid[1] = 1'b1;
        grant_start(1, 16'h0000, 64'h4000_0000, 16'h1111);
        finish_out(1, 16'h2000);

        // Clear and variance write while channel 1 is in flight.
        eng_xv     = 16'h1357;
        eng_pv     = 64'h0BAD_0000;
        z_valid[1] = 1'b1;
        grant_start(1, 16'h2000, 64'h2000_0000, 16'h1111);
        tick();
        cfg_we    = 1'b1;
        cfg_ch    = 2'd1;
        cfg_clr   = 1'b1;
        cfg_q_var = 64'h11;
        cfg_r_var = 64'h1234_5678;
        tick();
        cfg_we  = 1'b0;
        cfg_clr = 1'b0;
        chk("flight_r_var", eng_r_var, 64'h4000_0000);
        chk("flight_q_var", eng_q_var, 0);
        chk("flight_x", eng_x, 16'h2000);
        finish_out(1, 16'h1357);

        z_valid[1] = 1'b1;
        cfg_we     = 1'b1;
        #1;
        chk("cfg_blocks_grant", z_ready, 0);
        tick();
        cfg_we = 1'b0;
        grant_start(1, 16'h0000, 64'h4000_0000, 16'h1111);
        chk("new_r_var", eng_r_var, 64'h1234_5678);
        chk("new_q_var", eng_q_var, 64'h11);
        finish_out(1, 16'h1357);

        // Reset in the middle of WAIT.
        z_valid = 4'b1000;
        grant_start(3, 16'h2000, 64'h2000_0000, 16'h3333);
        tick();
        z_valid = 4'b0001;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_z_ready", z_ready, 0);
        chk("mid_rst_eng", {eng_start, eng_x, eng_z}, 0);
        chk("mid_rst_eng_p", eng_p, 0);
        chk("mid_rst_eng_qr", eng_q_var | eng_r_var, 0);
        chk("mid_rst_out", {out_valid, out_ch, out_x, timeout_err}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        grant_start(0, 16'h0000, 64'h4000_0000, 16'h4000);
        chk("post_rst_q_var", eng_q_var, 0);
        chk("post_rst_r_var", eng_r_var, 64'h4000_0000);
        finish_out(0, 16'h1357);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
